nco_clk_gen: RTL and testbench

Parametrised multi-channel clock-enable generator that sits directly behind the on-chip rPLL and replaces fixed-ratio PLL outputs for low-rate timing (sonar ping/sample rates, scan steps). It runs all channels off one PLL-derived fabric clock. Each channel's NCO phase accumulator produces a fractional-rate enable strobe. It gates all outputs on a debounced PLL lock and accepts glitch-free runtime frequency updates through a valid/ready handshake.

---
 rtl/nco_clk_gen_pkg.sv | 30 +++
 rtl/nco_channel.sv | 89 ++++++++
 rtl/nco_clk_gen.sv | 195 +++++++++++++++++++
 tb/tb_nco_clk_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/nco_clk_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nco_clk_gen_pkg
// Description : Shared types, legal parameter ranges and helper functions for
//               the nco_clk_gen multi-channel NCO clock-enable generator.
// Contents    : nco_state_e  - lock FSM state encoding (WAIT_LOCK, RUN)
//               ch_idx_w()   - channel-index width, never less than 1 bit
//               C_*_MIN/MAX  - legal ranges for NUM_CH, ACC_W, LOCK_CYCLES
// Revision    : 1.0 - initial release
// ============================================================================
package nco_clk_gen_pkg;

    localparam int C_NUM_CH_MIN      = 1;
    localparam int C_NUM_CH_MAX      = 16;
    localparam int C_ACC_W_MIN       = 8;
    localparam int C_ACC_W_MAX       = 48;
    localparam int C_LOCK_CYCLES_MIN = 2;

    typedef enum logic [0:0] {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } nco_state_e;

    // A single-channel build still needs a 1-bit select port.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nco_channel.sv
`default_nettype none
// ============================================================================
// Module      : nco_channel
// Description : One NCO channel: phase accumulator, active increment,
//               registered carry strobe and (optionally) registered MSB.
// Ports       : clk, reset      - clock, asynchronous active-high reset
//               run_en          - accumulate this cycle, else clear acc
//               upd_force       - apply a pending update without waiting
//               upd_req/upd_inc - pending increment targets this channel
//               upd_ack         - pending increment is applied this cycle
//               tick            - one-cycle strobe per accumulator carry
//               sq              - accumulator MSB (NCO_CLK_GEN_SQUARE_OUT_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module nco_channel
    import nco_clk_gen_pkg::*;
#(
    parameter int               ACC_W       = 32,
    parameter logic [ACC_W-1:0] DEFAULT_INC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_en,
    input  logic             upd_force,
    input  logic             upd_req,
    input  logic [ACC_W-1:0] upd_inc,
    output logic             upd_ack,
    output logic             tick
`ifdef NCO_CLK_GEN_SQUARE_OUT_EN
    ,
    output logic             sq
`endif
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic             tick_q, tick_d;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;

    assign w_sum   = {1'b0, acc_q} + {1'b0, inc_q};
    assign w_carry = run_en && w_sum[ACC_W];

    // Swapping the increment on the carry cycle keeps the current period
    // intact: the carry itself is computed with the old increment and the
    // new one only affects the period that starts after the wrap. A stopped
    // channel never carries, so it takes the update straight away.
    assign upd_ack = upd_req && (upd_force || (inc_q == '0) || w_carry);

    always_comb begin
        acc_d  = run_en ? w_sum[ACC_W-1:0] : '0;
        tick_d = w_carry;
        inc_d  = upd_ack ? upd_inc : inc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            inc_q  <= DEFAULT_INC;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            inc_q  <= inc_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

`ifdef NCO_CLK_GEN_SQUARE_OUT_EN
    logic sq_q, sq_d;

    always_comb begin
        sq_d = run_en ? w_sum[ACC_W-1] : 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq = sq_q;
`endif

endmodule
`default_nettype wire

// File: rtl/nco_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : nco_clk_gen
// Description : Multi-channel NCO clock-enable generator running behind the
//               PLL. Outputs are gated on a debounced, synchronised PLL lock;
//               per-channel increments are updated glitch-free through a
//               single-slot valid/ready handshake.
// Ports       : clk, reset      - fabric clock, asynchronous active-high reset
//               pll_lock        - raw PLL lock (asynchronous to clk)
//               cfg_valid/ready - increment update handshake
//               cfg_ch, cfg_inc - target channel and new increment
//               locked          - outputs running
//               tick[NUM_CH]    - one-cycle strobe per accumulator carry
//               sq[NUM_CH]      - accumulator MSB, present only when
//                                 NCO_CLK_GEN_SQUARE_OUT_EN is defined
// Macro       : NCO_CLK_GEN_SQUARE_OUT_EN - adds the sq outputs
// Revision    : 1.0 - initial release
// ============================================================================
module nco_clk_gen
    import nco_clk_gen_pkg::*;
#(
    parameter int               NUM_CH      = 4,
    parameter int               ACC_W       = 32,
    parameter int               LOCK_CYCLES = 1024,
    parameter logic [ACC_W-1:0] DEFAULT_INC = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pll_lock,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]            cfg_inc,
    output logic                        locked,
    output logic [NUM_CH-1:0]           tick
`ifdef NCO_CLK_GEN_SQUARE_OUT_EN
    ,
    output logic [NUM_CH-1:0]           sq
`endif
);

    localparam int                C_CH_W     = ch_idx_w(NUM_CH);
    localparam int                C_CNT_W    = $clog2(LOCK_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(LOCK_CYCLES - 1);

    if ((NUM_CH < C_NUM_CH_MIN) || (NUM_CH > C_NUM_CH_MAX) ||
        (ACC_W < C_ACC_W_MIN) || (ACC_W > C_ACC_W_MAX) ||
        (LOCK_CYCLES < C_LOCK_CYCLES_MIN)) begin : g_bad_params
        $error("nco_clk_gen: parameter out of legal range");
    end

    // ------------------------------------------------------------------
    // Lock synchroniser
    // ------------------------------------------------------------------
    logic lock_meta_q;
    logic lock_s_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM and debounce counter
    // ------------------------------------------------------------------
    nco_state_e         state_q, state_d;
    logic [C_CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (!lock_s_q) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == C_CNT_LAST) begin
                    state_d    = RUN;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s_q) begin
                    state_d    = WAIT_LOCK;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = WAIT_LOCK;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= WAIT_LOCK;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // The cycle that sees lock drop while still in RUN is already treated
    // as stopped, so accumulators clear together with the state change.
    logic w_run_en;
    logic w_upd_force;

    assign w_run_en    = (state_q == RUN) && lock_s_q;
    assign w_upd_force = (state_q == WAIT_LOCK);
    assign locked      = (state_q == RUN);

    // ------------------------------------------------------------------
    // Pending update slot
    // ------------------------------------------------------------------
    logic              pend_valid_q, pend_valid_d;
    logic [C_CH_W-1:0] pend_ch_q, pend_ch_d;
    logic [ACC_W-1:0]  pend_inc_q, pend_inc_d;
    logic              w_pend_ch_bad;
    logic [NUM_CH-1:0] w_upd_ack;
    logic              w_pend_done;

    // Out-of-range channel numbers only exist when NUM_CH is not a power of 2.
    if (NUM_CH == (2 ** C_CH_W)) begin : g_ch_full
        assign w_pend_ch_bad = 1'b0;
    end else begin : g_ch_partial
        assign w_pend_ch_bad = (pend_ch_q > C_CH_W'(NUM_CH - 1));
    end

    assign w_pend_done = w_pend_ch_bad || (|w_upd_ack);
    assign cfg_ready   = !pend_valid_q;

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_ch_d    = pend_ch_q;
        pend_inc_d   = pend_inc_q;
        if (pend_valid_q) begin
            if (w_pend_done) begin
                pend_valid_d = 1'b0;
            end
        end else if (cfg_valid) begin
            pend_valid_d = 1'b1;
            pend_ch_d    = cfg_ch;
            pend_inc_d   = cfg_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_ch_q    <= '0;
            pend_inc_q   <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_ch_q    <= pend_ch_d;
            pend_inc_q   <= pend_inc_d;
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_upd_req;

        assign w_upd_req = pend_valid_q && (pend_ch_q == C_CH_W'(i));

        nco_channel #(
            .ACC_W       (ACC_W),
            .DEFAULT_INC (DEFAULT_INC)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .run_en    (w_run_en),
            .upd_force (w_upd_force),
            .upd_req   (w_upd_req),
            .upd_inc   (pend_inc_q),
            .upd_ack   (w_upd_ack[i]),
            .tick      (tick[i])
`ifdef NCO_CLK_GEN_SQUARE_OUT_EN
            ,
            .sq        (sq[i])
`endif
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_nco_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_nco_clk_gen
// Description : Self-checking bench for nco_clk_gen (NUM_CH=3, ACC_W=8,
//               LOCK_CYCLES=4). Expected tick events are queued by the
//               stimulus process; a monitor pops one per observed tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_clk_gen;

    localparam int NUM_CH = 3;

    typedef struct {
        int                cyc;
        logic [NUM_CH-1:0] mask;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              pll_lock;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [7:0]        cfg_inc;
    logic              locked;
    logic [NUM_CH-1:0] tick;
`ifdef NCO_CLK_GEN_SQUARE_OUT_EN
    logic [NUM_CH-1:0] sq;
`endif

    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    nco_clk_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (8),
        .LOCK_CYCLES (4),
        .DEFAULT_INC (8'd0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .locked    (locked),
        .tick      (tick)
`ifdef NCO_CLK_GEN_SQUARE_OUT_EN
        ,
        .sq        (sq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total = n_total + 1;
        if (act === req) n_pass = n_pass + 1;
        else $display("FAIL %s: cycle %0d got %0d, required %0d", name, cyc, act, req);
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every tick presented by the DUT must match the next queued one.
    always @(negedge clk) begin
        exp_t e;
        if (tick !== '0) begin
            n_total = n_total + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL tick_unexpected: cycle %0d got mask %b, required none", cyc, tick);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc == cyc && e.mask === tick) n_pass = n_pass + 1;
                else $display("FAIL tick: cycle %0d got mask %b, required cycle %0d mask %b",
                              cyc, tick, e.cyc, e.mask);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int                k0, r, r2, k1;
        logic [NUM_CH-1:0] m;

        reset = 1'b1; pll_lock = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_locked", locked, 0);
        chk("rst_tick", tick, 0);
        chk("rst_ready", cfg_ready, 1);
`ifdef NCO_CLK_GEN_SQUARE_OUT_EN
        chk("rst_sq", sq, 0);
`endif

        // Release with lock already high: RUN six edges later.
        reset = 1'b0;
        k0 = cyc;
        r  = k0 + 6;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd128;

        // ch0: 128 until the carry at r+12, 64 until the carry at r+20,
        // then 128 again. ch1 (inc 3) first wraps at 3*86 = 258.
        for (int n = 1; n <= 97; n++) begin
            m = '0;
            if ((n <= 12 && n % 2 == 0) || (n > 12 && n <= 20 && n % 4 == 0) ||
                (n > 20 && n % 2 == 0)) m[0] = 1'b1;
            if (n == 86) m[1] = 1'b1;
            if (m != '0) exp_q.push_back('{r + n, m});
        end

        for (int j = 1; j <= 6; j++) begin
            at_cyc(k0 + j);
            chk("lock_latency", locked, (j == 6));
            case (j)
                1: begin cfg_valid = 1'b0; chk("wl_ready_busy", cfg_ready, 0); end
                2: begin
                    chk("wl_ready_free", cfg_ready, 1);
                    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = 8'd3;
                end
                3: begin cfg_valid = 1'b0; chk("wl_ready_busy2", cfg_ready, 0); end
                4: chk("wl_ready_free2", cfg_ready, 1);
                default: ;
            endcase
        end

        // ch0 128 -> 64 written just before a carry.
        at_cyc(r + 9);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd64;
        at_cyc(r + 10); cfg_valid = 1'b0; chk("upd1_busy_a", cfg_ready, 0);
        at_cyc(r + 11); chk("upd1_busy_b", cfg_ready, 0);
        at_cyc(r + 12); chk("upd1_free", cfg_ready, 1);

        // ch0 64 -> 128 written mid-period.
        at_cyc(r + 17);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd128;
        at_cyc(r + 18); cfg_valid = 1'b0; chk("upd2_busy_a", cfg_ready, 0);
        at_cyc(r + 19); chk("upd2_busy_b", cfg_ready, 0);
        at_cyc(r + 20); chk("upd2_free", cfg_ready, 1);

        // One-cycle lock glitch.
        at_cyc(r + 95); pll_lock = 1'b0;
        at_cyc(r + 96); pll_lock = 1'b1;
        at_cyc(r + 97); chk("drop_locked_hold", locked, 1);
        at_cyc(r + 98); chk("drop_locked_low", locked, 0);

        // Relock 6 edges after pll_lock rises. Accumulators restart from 0:
        // ch0 even cycles; ch2 (0 -> 128 at r2+5) odd cycles from r2+7.
        r2 = r + 102;
        for (int n = 1; n <= 20; n++) begin
            m = '0;
            if (n % 2 == 0) m[0] = 1'b1;
            if (n >= 7 && n % 2 == 1) m[2] = 1'b1;
            if (m != '0) exp_q.push_back('{r2 + n, m});
        end
        at_cyc(r2 - 1); chk("relock_wait", locked, 0);
        at_cyc(r2);     chk("relock_run", locked, 1);

        // Update to a stopped channel applies on the next cycle.
        at_cyc(r2 + 3);
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 8'd128;
        at_cyc(r2 + 4); cfg_valid = 1'b0; chk("zero_busy", cfg_ready, 0);
        at_cyc(r2 + 5); chk("zero_free", cfg_ready, 1);

        // Out-of-range channel is accepted and dropped.
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 8'd1;
        at_cyc(r2 + 6); cfg_valid = 1'b0; chk("badch_busy", cfg_ready, 0);
        at_cyc(r2 + 7); chk("badch_free", cfg_ready, 1);

        // Asynchronous reset with an update still pending.
        at_cyc(r2 + 19);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd64;
        at_cyc(r2 + 20); cfg_valid = 1'b0; chk("pend_busy", cfg_ready, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_locked", locked, 0);
        chk("async_tick", tick, 0);
        chk("async_ready", cfg_ready, 1);

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        k1 = cyc;
        for (int j = 1; j <= 6; j++) begin
            at_cyc(k1 + j);
            chk("post_rst_lock", locked, (j == 6));
        end
        // All incs are back at 0 and the pending write is gone: no ticks.
        at_cyc(k1 + 20);
        chk("post_rst_ready", cfg_ready, 1);
        chk("tick_missing", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
